// File: rtl/i2c_slave_regfile.sv
`default_nettype none
// ============================================================================
// Module   : i2c_slave_regfile
// Brief    : I2C slave address matcher with per-address byte storage and an
//            auto-incrementing per-transaction byte pointer.
// Revision : 1.0 - initial release
// ============================================================================
module i2c_slave_regfile #(
    parameter int ADDRESSLENGTH = 7,
    parameter int ADDRESSNUM    = 4,
    parameter int NBYTES        = 2
) (
    input  logic                                Clk,
    input  logic                                Reset_n,
    input  logic [ADDRESSLENGTH*ADDRESSNUM-1:0] AddressList,
    input  logic                                MatchReq,
    input  logic [ADDRESSLENGTH-1:0]            AddrIn,
    input  logic                                WrStb,
    input  logic [7:0]                          WrData,
    input  logic                                RdStb,
    input  logic                                StopStb,
    output logic                                MatchValid,
    output logic                                AddressFound,
    output logic [4:0]                          LocalAddressID,
    output logic [7:0]                          RdData,
    output logic                                RdValid,
    output logic                                PtrWrap,
    output logic                                CollisionErr
);

    localparam int c_PTR_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam int c_SLOT_W = (ADDRESSNUM > 1) ? $clog2(ADDRESSNUM) : 1;
    localparam logic [c_PTR_W-1:0] c_PTR_LAST = c_PTR_W'(NBYTES - 1);

    typedef enum logic [0:0] {
        ST_IDLE     = 1'b0,
        ST_SELECTED = 1'b1
    } state_t;

    state_t                r_state;
    logic [c_PTR_W-1:0]    r_ptr;
    logic [7:0]            r_mem [ADDRESSNUM][NBYTES];

    logic [ADDRESSNUM-1:0] w_slotHit;
    logic                  w_anyHit;
    logic [4:0]            w_hitIdx;
    logic [c_SLOT_W-1:0]   w_slot;
    logic                  w_ptrWrap;
    logic [c_PTR_W-1:0]    w_ptrNext;
    logic                  w_access;

    generate
        for (genvar gi = 0; gi < ADDRESSNUM; gi++) begin : g_cmp
            assign w_slotHit[gi] = (AddressList[gi*ADDRESSLENGTH +: ADDRESSLENGTH] == AddrIn);
        end
    endgenerate

    // Scan from the top so the lowest matching slot wins on duplicates.
    always_comb begin
        w_anyHit = 1'b0;
        w_hitIdx = '0;
        for (int i = ADDRESSNUM - 1; i >= 0; i--) begin
            if (w_slotHit[i]) begin
                w_anyHit = 1'b1;
                w_hitIdx = 5'(i);
            end
        end
    end

    assign w_slot    = LocalAddressID[c_SLOT_W-1:0];
    assign w_ptrWrap = (r_ptr == c_PTR_LAST);
    assign w_ptrNext = w_ptrWrap ? '0 : r_ptr + 1'b1;
    assign w_access  = (r_state == ST_SELECTED) && (WrStb || RdStb);

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state        <= ST_IDLE;
            r_ptr          <= '0;
            MatchValid     <= 1'b0;
            AddressFound   <= 1'b0;
            LocalAddressID <= '0;
            RdData         <= '0;
            RdValid        <= 1'b0;
            PtrWrap        <= 1'b0;
            CollisionErr   <= 1'b0;
            for (int s = 0; s < ADDRESSNUM; s++) begin
                for (int b = 0; b < NBYTES; b++) begin
                    r_mem[s][b] <= 8'h00;
                end
            end
        end else begin
            MatchValid   <= 1'b0;
            RdValid      <= 1'b0;
            PtrWrap      <= 1'b0;
            CollisionErr <= 1'b0;

            if (MatchReq) begin
                MatchValid <= 1'b1;
                r_ptr      <= '0;
                if (w_anyHit) begin
                    AddressFound   <= 1'b1;
                    LocalAddressID <= w_hitIdx;
                    r_state        <= ST_SELECTED;
                end else begin
                    AddressFound   <= 1'b0;
                    LocalAddressID <= '0;
                    r_state        <= ST_IDLE;
                end
            end else if (StopStb) begin
                r_state      <= ST_IDLE;
                AddressFound <= 1'b0;
                r_ptr        <= '0;
            end else if (w_access) begin
                // A simultaneous read is dropped in favour of the write.
                if (WrStb) begin
                    r_mem[w_slot][r_ptr] <= WrData;
                end else begin
                    RdData  <= r_mem[w_slot][r_ptr];
                    RdValid <= 1'b1;
                end
                CollisionErr <= WrStb && RdStb;
                PtrWrap      <= w_ptrWrap;
                r_ptr        <= w_ptrNext;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_i2c_slave_regfile.sv
`default_nettype none
// ============================================================================
// Module   : tb_i2c_slave_regfile
// Brief    : Scoreboard bench for i2c_slave_regfile with a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_i2c_slave_regfile;

    localparam int AL = 7;
    localparam int AN = 4;
    localparam int NB = 2;

    logic          Clk;
    logic          Reset_n;
    logic [AL*AN-1:0] AddressList;
    logic          MatchReq;
    logic [AL-1:0] AddrIn;
    logic          WrStb;
    logic [7:0]    WrData;
    logic          RdStb;
    logic          StopStb;
    logic          MatchValid;
    logic          AddressFound;
    logic [4:0]    LocalAddressID;
    logic [7:0]    RdData;
    logic          RdValid;
    logic          PtrWrap;
    logic          CollisionErr;

    i2c_slave_regfile #(.ADDRESSLENGTH(AL), .ADDRESSNUM(AN), .NBYTES(NB)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .AddressList(AddressList),
        .MatchReq(MatchReq), .AddrIn(AddrIn), .WrStb(WrStb), .WrData(WrData),
        .RdStb(RdStb), .StopStb(StopStb), .MatchValid(MatchValid),
        .AddressFound(AddressFound), .LocalAddressID(LocalAddressID),
        .RdData(RdData), .RdValid(RdValid), .PtrWrap(PtrWrap),
        .CollisionErr(CollisionErr)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        int         cyc;
        bit         mv;
        bit         rv;
        bit         wrap;
        bit         coll;
        logic [7:0] rd;
    } exp_t;

    exp_t       q[$];
    int         total = 0;
    int         bad   = 0;
    int         edgeCount = 0;

    // Behavioural model state
    logic [AL-1:0] lst [AN];
    logic [7:0]    mMem [AN][NB];
    bit            mSel;
    int            mPtr;
    logic          expFound;
    logic [4:0]    expId;
    logic [7:0]    expRd;

    always_comb AddressList = {lst[3], lst[2], lst[1], lst[0]};

    task automatic modelReset();
        for (int s = 0; s < AN; s++)
            for (int b = 0; b < NB; b++) mMem[s][b] = 8'h00;
        mSel = 0; mPtr = 0;
        expFound = 0; expId = 0; expRd = 0;
        q.delete();
    endtask

    // Applies one cycle of stimulus and predicts the response of the next edge.
    task automatic drive(input bit m, input logic [AL-1:0] a, input bit w,
                         input logic [7:0] wd, input bit r, input bit s);
        exp_t e;
        int   hit;
        @(negedge Clk);
        MatchReq = m; AddrIn = a; WrStb = w; WrData = wd; RdStb = r; StopStb = s;
        e.cyc = edgeCount + 1; e.mv = 0; e.rv = 0; e.wrap = 0; e.coll = 0; e.rd = expRd;
        if (m) begin
            hit = -1;
            for (int i = 0; i < AN; i++) if (hit < 0 && lst[i] == a) hit = i;
            e.mv = 1; mPtr = 0;
            mSel = (hit >= 0);
            expFound = (hit >= 0);
            expId = (hit >= 0) ? 5'(hit) : 5'd0;
        end else if (s) begin
            mSel = 0; expFound = 0; mPtr = 0;
        end else if (mSel && (w || r)) begin
            if (w) mMem[expId][mPtr] = wd;
            else begin
                expRd = mMem[expId][mPtr];
                e.rv = 1; e.rd = expRd;
            end
            e.coll = w && r;
            e.wrap = (mPtr == NB - 1);
            mPtr = (mPtr + 1) % NB;
        end
        if (e.mv || e.rv || e.wrap || e.coll) q.push_back(e);
    endtask

    task automatic idle(); drive(0, '0, 0, '0, 0, 0); endtask
    task automatic match(input logic [AL-1:0] a); drive(1, a, 0, '0, 0, 0); endtask
    task automatic wr(input logic [7:0] d); drive(0, '0, 1, d, 0, 0); endtask
    task automatic rd(); drive(0, '0, 0, '0, 1, 0); endtask
    task automatic stop(); drive(0, '0, 0, '0, 0, 1); endtask

    task automatic checkAllZero(input string name);
        total++;
        if ({MatchValid, AddressFound, LocalAddressID, RdData, RdValid, PtrWrap, CollisionErr} !== '0) begin
            bad++;
            $display("FAIL %s: outputs mv=%b af=%b id=%0d rd=%h rv=%b wrap=%b coll=%b, required all 0",
                     name, MatchValid, AddressFound, LocalAddressID, RdData, RdValid, PtrWrap, CollisionErr);
        end
    endtask

    // Asserts reset between edges, right after the previous cycle's strobes were taken.
    task automatic asyncReset();
        @(posedge Clk);
        #3;
        Reset_n = 1'b0;
        MatchReq = 0; WrStb = 0; RdStb = 0; StopStb = 0;
        modelReset();
        #1;
        checkAllZero("async_reset");
        @(negedge Clk);
        @(negedge Clk);
        Reset_n = 1'b1;
    endtask

    // Monitor: checks levels every cycle and pops the scoreboard on pulses.
    initial begin
        exp_t e;
        forever begin
            @(posedge Clk);
            edgeCount++;
            #1;
            total++;
            if ({AddressFound, LocalAddressID, RdData} !== {expFound, expId, expRd}) begin
                bad++;
                $display("FAIL levels @%0d: af=%b id=%0d rd=%h, required af=%b id=%0d rd=%h",
                         edgeCount, AddressFound, LocalAddressID, RdData, expFound, expId, expRd);
            end
            total++;
            if (q.size() > 0 && q[0].cyc == edgeCount) begin
                e = q.pop_front();
                if ({MatchValid, RdValid, PtrWrap, CollisionErr} !== {e.mv, e.rv, e.wrap, e.coll}) begin
                    bad++;
                    $display("FAIL pulses @%0d: mv/rv/wrap/coll=%b%b%b%b, required %b%b%b%b",
                             edgeCount, MatchValid, RdValid, PtrWrap, CollisionErr,
                             e.mv, e.rv, e.wrap, e.coll);
                end else if (e.rv && RdData !== e.rd) begin
                    bad++;
                    $display("FAIL rddata @%0d: got %h, required %h", edgeCount, RdData, e.rd);
                end
            end else if (MatchValid || RdValid || PtrWrap || CollisionErr) begin
                bad++;
                $display("FAIL spurious @%0d: mv/rv/wrap/coll=%b%b%b%b, required none",
                         edgeCount, MatchValid, RdValid, PtrWrap, CollisionErr);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        lst[0] = 7'h10; lst[1] = 7'h55; lst[2] = 7'h7F; lst[3] = 7'h55;
        Reset_n = 1'b0;
        MatchReq = 0; AddrIn = '0; WrStb = 0; WrData = '0; RdStb = 0; StopStb = 0;
        modelReset();
        repeat (3) @(negedge Clk);
        checkAllZero("reset_held");
        Reset_n = 1'b1;
        #1;
        checkAllZero("reset_released");

        // Miss, then ignored write while idle
        match(7'h2F); wr(8'hEE); idle();
        // Duplicate address resolves to lowest slot; write two bytes with wrap
        match(7'h55); wr(8'hA5); wr(8'hF5); stop();
        match(7'h55); rd(); rd(); idle();
        // Untouched slot reads zero; wrap on the second read
        match(7'h7F); rd(); rd(); rd(); stop();
        // Collision: write wins, read dropped
        match(7'h55); drive(0, '0, 1, 8'h3C, 1, 0); stop();
        match(7'h55); rd(); rd();
        // Match in the same cycle as a write drops the write
        match(7'h55); wr(8'h11); drive(1, 7'h10, 1, 8'h22, 0, 0); rd(); rd();
        match(7'h55); rd(); rd(); stop();
        // Reset in the middle of a write sequence, then all slots read zero
        match(7'h10); wr(8'h99);
        drive(0, '0, 1, 8'h77, 0, 0);
        asyncReset();
        for (int s = 0; s < AN; s++) begin
            match(lst[s]); rd(); rd(); stop();
        end

        // Randomised traffic, first with the fixed list, then with random lists
        for (int phase = 0; phase < 3; phase++) begin
            if (phase > 0) begin
                stop();
                for (int i = 0; i < AN; i++)
                    lst[i] = ($urandom_range(0, 2) == 0) ? lst[$urandom_range(0, AN - 1)] : 7'($urandom);
            end
            for (int n = 0; n < 300; n++) begin
                bit m, w, r, s;
                logic [AL-1:0] a;
                m = ($urandom_range(0, 9) == 0);
                s = ($urandom_range(0, 19) == 0);
                w = ($urandom_range(0, 2) == 0);
                r = ($urandom_range(0, 2) == 0);
                a = ($urandom_range(0, 9) < 7) ? lst[$urandom_range(0, AN - 1)] : 7'($urandom);
                drive(m, a, w, 8'($urandom), r, s);
                if (phase == 1 && n == 150) asyncReset();
            end
        end

        repeat (3) idle();
        @(negedge Clk);
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: %0d expected pulses never seen, required 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
